// File: rtl/apb_uart_cmd_master.sv
// Single-outstanding APB master: turns a valid/ready write-byte/read-word command into a
// SETUP/ACCESS transfer, with a bounded PREADY wait and a valid/ready response channel.
module apb_uart_cmd_master #(
   parameter int unsigned ADDR_W         = 12,
   parameter int unsigned WDATA_W        = 8,
   parameter int unsigned RDATA_W        = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned CNT_W          = 8
) (
   input  logic               PCLK,
   input  logic               PRESETn,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_write,
   input  logic [ADDR_W-1:0]  req_addr,
   input  logic [WDATA_W-1:0] req_wdata,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [RDATA_W-1:0] rsp_rdata,
   output logic               rsp_timeout,
   output logic               busy,
   output logic [CNT_W-1:0]   timeout_count,
   output logic               PSEL,
   output logic               PENABLE,
   output logic               PWRITE,
   output logic [ADDR_W-1:0]  PADDR,
   output logic [WDATA_W-1:0] PWDATA,
   input  logic               PREADY,
   input  logic [RDATA_W-1:0] PRDATA
);

   localparam int unsigned WaitW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WaitW-1:0] WaitLast =
      (TIMEOUT_CYCLES == 0) ? '0 : WaitW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

   state_e               state_q, state_d;
   logic                 psel_q, psel_d;
   logic                 penable_q, penable_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic                 busy_q, busy_d;
   logic                 pwrite_q, pwrite_d;
   logic [ADDR_W-1:0]    paddr_q, paddr_d;
   logic [WDATA_W-1:0]   pwdata_q, pwdata_d;
   logic [RDATA_W-1:0]   rdata_q, rdata_d;
   logic                 timeout_q, timeout_d;
   logic [CNT_W-1:0]     tcnt_q, tcnt_d;
   logic [WaitW-1:0]     wait_q, wait_d;

   always_comb begin
      state_d     = state_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      rsp_valid_d = rsp_valid_q;
      busy_d      = busy_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rdata_d     = rdata_q;
      timeout_d   = timeout_q;
      tcnt_d      = tcnt_q;
      wait_d      = wait_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               state_d  = StSetup;
               psel_d   = 1'b1;
               busy_d   = 1'b1;
               pwrite_d = req_write;
               paddr_d  = req_addr;
               pwdata_d = req_wdata;
               wait_d   = '0;
            end
         end
         StSetup: begin
            state_d   = StAccess;
            penable_d = 1'b1;
         end
         StAccess: begin
            // PREADY takes priority over an expiring wait budget.
            if (PREADY) begin
               state_d     = StResp;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rdata_d     = pwrite_q ? '0 : PRDATA;
               timeout_d   = 1'b0;
            end else if (TIMEOUT_CYCLES != 0 && wait_q == WaitLast) begin
               state_d     = StResp;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rdata_d     = '0;
               timeout_d   = 1'b1;
               if (tcnt_q != '1) tcnt_d = tcnt_q + CNT_W'(1);
            end else begin
               wait_d = wait_q + WaitW'(1);
            end
         end
         StResp: begin
            if (rsp_ready) begin
               state_d     = StIdle;
               rsp_valid_d = 1'b0;
               busy_d      = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q     <= StIdle;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rdata_q     <= '0;
         timeout_q   <= 1'b0;
         tcnt_q      <= '0;
         wait_q      <= '0;
      end else begin
         state_q     <= state_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rdata_q     <= rdata_d;
         timeout_q   <= timeout_d;
         tcnt_q      <= tcnt_d;
         wait_q      <= wait_d;
      end
   end

   // Held low during reset even though the state register already reads IDLE.
   assign req_ready     = (state_q == StIdle) & PRESETn;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_rdata     = rdata_q;
   assign rsp_timeout   = timeout_q;
   assign busy          = busy_q;
   assign timeout_count = tcnt_q;
   assign PSEL          = psel_q;
   assign PENABLE       = penable_q;
   assign PWRITE        = pwrite_q;
   assign PADDR         = paddr_q;
   assign PWDATA        = pwdata_q;

endmodule

// File: tb/tb_apb_uart_cmd_master.sv
// Directed plus randomized bench for apb_uart_cmd_master with a transaction-level model
// of expected latency, read data, timeout status and the saturating timeout counter.
module tb_apb_uart_cmd_master;

   localparam int unsigned ToCycles = 16;

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic        req_valid, req_ready, req_write;
   logic [11:0] req_addr;
   logic [7:0]  req_wdata;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_timeout, busy;
   logic [7:0]  timeout_count;
   logic        PSEL, PENABLE, PWRITE;
   logic [11:0] PADDR;
   logic [7:0]  PWDATA;
   logic        PREADY;
   logic [31:0] PRDATA;

   int unsigned n_checks = 0;
   int unsigned n_err    = 0;
   logic [7:0]  tcnt_exp = 8'h00;

   apb_uart_cmd_master dut (
      .PCLK          (PCLK),
      .PRESETn       (PRESETn),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_write     (req_write),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_rdata     (rsp_rdata),
      .rsp_timeout   (rsp_timeout),
      .busy          (busy),
      .timeout_count (timeout_count),
      .PSEL          (PSEL),
      .PENABLE       (PENABLE),
      .PWRITE        (PWRITE),
      .PADDR         (PADDR),
      .PWDATA        (PWDATA),
      .PREADY        (PREADY),
      .PRDATA        (PRDATA)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   // One full command: accept, SETUP, ACCESS with `waits` PREADY-low cycles, RESP held
   // for `bp` cycles of backpressure, then handshake back to IDLE.
   task automatic do_txn(input logic wr, input logic [11:0] addr, input logic [7:0] wd,
                         input int waits, input logic [31:0] prd, input int bp,
                         input logic setup_rdy);
      int          cycles;
      int          exp_cyc;
      logic        tmo;
      logic [31:0] exp_rd;
      tmo     = (waits >= int'(ToCycles));
      exp_cyc = tmo ? int'(ToCycles) : waits + 1;
      exp_rd  = (tmo || wr) ? 32'h0 : prd;
      if (tmo && tcnt_exp != 8'hFF) tcnt_exp = tcnt_exp + 8'h01;

      chk("req_ready_idle", req_ready, 1);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      tick();
      req_valid = 1'b0;
      req_write = ~wr;
      req_addr  = 12'($urandom);
      req_wdata = 8'($urandom);
      chk("setup_psel", PSEL, 1);
      chk("setup_penable", PENABLE, 0);
      chk("setup_pwrite", PWRITE, wr);
      chk("setup_paddr", PADDR, addr);
      chk("setup_pwdata", PWDATA, wd);
      chk("setup_busy", busy, 1);
      chk("setup_req_ready", req_ready, 0);
      PREADY = setup_rdy;
      PRDATA = 32'hDEADBEEF;
      tick();
      cycles = 0;
      while (PENABLE === 1'b1 && cycles < 40) begin
         chk("access_psel", PSEL, 1);
         chk("access_paddr", PADDR, addr);
         chk("access_pwdata", PWDATA, wd);
         PREADY = (cycles == waits);
         PRDATA = PREADY ? prd : 32'hDEADBEEF;
         tick();
         cycles++;
      end
      PREADY = 1'b0;
      PRDATA = 32'($urandom);
      chk("penable_cycles", 32'(cycles), 32'(exp_cyc));
      for (int i = 0; i <= bp; i++) begin
         chk("resp_valid", rsp_valid, 1);
         chk("resp_psel", PSEL, 0);
         chk("resp_req_ready", req_ready, 0);
         chk("resp_rdata", rsp_rdata, exp_rd);
         chk("resp_timeout", rsp_timeout, tmo);
         chk("timeout_count", timeout_count, tcnt_exp);
         if (i == bp) rsp_ready = 1'b1;
         tick();
      end
      rsp_ready = 1'b0;
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_paddr_kept", PADDR, addr);
   endtask

   initial begin
      PRESETn   = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b0;
      PREADY    = 1'b0;
      PRDATA    = '0;
      #1;
      chk("rst_psel", PSEL, 0);
      chk("rst_penable", PENABLE, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_paddr", PADDR, 0);
      chk("rst_pwdata", PWDATA, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_tcnt", timeout_count, 0);
      #12 PRESETn = 1'b1;
      tick();

      // Zero-wait write, slow read, exact-boundary completion, early PREADY in SETUP.
      do_txn(1'b1, 12'h004, 8'hA5, 0, 32'h0, 0, 1'b0);
      do_txn(1'b0, 12'h004, 8'h00, 5, 32'h0000_00A5, 0, 1'b0);
      do_txn(1'b0, 12'h010, 8'h00, 15, 32'h1234_5678, 0, 1'b0);
      do_txn(1'b0, 12'h020, 8'h00, 2, 32'hCAFE_F00D, 0, 1'b1);
      // Backpressure, then a back-to-back command.
      do_txn(1'b0, 12'h030, 8'h00, 0, 32'h0BAD_CAFE, 10, 1'b0);
      do_txn(1'b1, 12'h031, 8'h3C, 0, 32'h0, 0, 1'b0);

      // Repeated timeouts drive the counter into saturation.
      for (int i = 0; i < 300; i++)
         do_txn(1'($urandom), 12'($urandom), 8'($urandom), 16 + int'($urandom_range(0, 3)),
                32'($urandom), 0, 1'($urandom));
      chk("tcnt_saturated", timeout_count, 8'hFF);

      for (int i = 0; i < 60; i++)
         do_txn(1'($urandom), 12'($urandom), 8'($urandom), int'($urandom_range(0, 18)),
                32'($urandom), int'($urandom_range(0, 3)), 1'($urandom));

      // Asynchronous reset in the middle of ACCESS.
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 12'h0FF;
      tick();
      req_valid = 1'b0;
      tick();
      chk("pre_rst_penable", PENABLE, 1);
      #2 PRESETn = 1'b0;
      #1;
      chk("mid_rst_psel", PSEL, 0);
      chk("mid_rst_penable", PENABLE, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_req_ready", req_ready, 0);
      chk("mid_rst_tcnt", timeout_count, 0);
      tcnt_exp = 8'h00;
      #3 PRESETn = 1'b1;
      tick();
      do_txn(1'b1, 12'h004, 8'hA5, 0, 32'h0, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/apb_uart_cmd_master.md
Name: apb_uart_cmd_master

Overview:
Single-outstanding APB master that sits directly upstream of the APB_UART slave port. It converts a simple valid/ready command stream (write byte / read word) from the host-side controller into a compliant two-phase APB transfer (SETUP, then ACCESS), waiting on PREADY. It returns the read data and a timeout status on a valid/ready response channel. A bounded wait aborts transfers whose slave never asserts PREADY.

Parameters:
ADDR_W, 12, APB address width (PADDR, req_addr)
WDATA_W, 8, write data width (PWDATA, req_wdata)
RDATA_W, 32, read data width (PRDATA, rsp_rdata)
TIMEOUT_CYCLES, 16, max ACCESS cycles with PREADY low before abort; 0 disables timeout
CNT_W, 8, width of timeout event counter

Ports:
PCLK  in  1  sole clock, rising edge
PRESETn  in  1  reset, asynchronous assert, active-low
req_valid  in  1  command valid
req_ready  out  1  command accepted when req_valid & req_ready
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  target address
req_wdata  in  WDATA_W  write data
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  out  RDATA_W  captured PRDATA (reads); 0 for writes and timeouts
rsp_timeout  out  1  transfer aborted by timeout
busy  out  1  high in any state other than IDLE
timeout_count  out  CNT_W  saturating count of timeout events
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_W  APB address
PWDATA  out  WDATA_W  APB write data
PREADY  in  1  slave ready
PRDATA  in  RDATA_W  slave read data

Behaviour:
- Reset (PRESETn low, takes effect immediately, no clock edge needed): state IDLE. All outputs 0, including PADDR, PWDATA, rsp_rdata and timeout_count. The exception is req_ready, which goes to 1 only after PRESETn deasserts (req_ready = state==IDLE, but it is 0 while PRESETn is low).
- States:
  - IDLE: req_ready=1. On handshake, register write/addr/wdata and go to SETUP.
  - SETUP: PSEL=1, PENABLE=0, PWRITE/PADDR/PWDATA driven from the registers. Unconditionally go to ACCESS on the next edge.
  - ACCESS: PSEL=1, PENABLE=1, all APB outputs held stable. If PREADY=1, capture PRDATA into rsp_rdata (read) or load 0 (write), set rsp_timeout=0, go to RESP. Else if TIMEOUT_CYCLES≠0 and wait counter == TIMEOUT_CYCLES-1, set rsp_rdata=0, rsp_timeout=1, increment timeout_count (saturate at all-ones), go to RESP. Else increment the wait counter.
  - RESP: PSEL=PENABLE=0, rsp_valid=1. rsp_rdata and rsp_timeout are held stable until rsp_ready. On handshake go to IDLE.
- Wait counter: cleared on entry to SETUP, counts ACCESS cycles with PREADY low. Width is $clog2(TIMEOUT_CYCLES+1).
- Latency: handshake at edge N → PSEL=1 after N, PENABLE=1 after N+1. With zero-wait PREADY, rsp_valid=1 after N+2.
  - Minimum command-to-command spacing is 4 cycles (IDLE, SETUP, ACCESS, RESP).
  - req_ready is combinational from state only, never from req_valid.
- PADDR/PWDATA/PWRITE keep their last value after a transfer (not cleared). PSEL/PENABLE are 0 outside SETUP/ACCESS.
- PRDATA is sampled only in ACCESS with PREADY=1. Values at any other time are ignored.
- PREADY is ignored outside ACCESS, including an early PREADY during SETUP.
- Simultaneous PREADY=1 and timeout threshold in the same cycle: PREADY wins (normal completion, no timeout).
- rsp_ready held low: stay in RESP indefinitely with response stable and req_ready=0.
- Reset mid-transfer: APB outputs drop to 0 immediately and any pending response is discarded. timeout_count clears.
- req_addr/req_wdata changes after acceptance have no effect on the transfer in flight.

Test Plan:
1. Write 0xA5 to 0x004, PREADY tied 1, rsp_ready=1 → PSEL rises 1 cycle after accept, PENABLE 1 cycle later for exactly 1 cycle, PWRITE=1, PADDR=0x004, PWDATA=0xA5; rsp_valid 3 cycles after accept with rsp_rdata=0, rsp_timeout=0.
2. Read 0x004, PREADY low 5 ACCESS cycles then high with PRDATA=0x000000A5 (junk 0xDEADBEEF while PREADY low) → PENABLE high 6 cycles, rsp_rdata=0x000000A5, rsp_timeout=0.
3. Read with PREADY held 0, TIMEOUT_CYCLES=16 → PENABLE high exactly 16 cycles then drops; rsp_timeout=1, rsp_rdata=0, timeout_count=1; repeat 300 times → timeout_count saturates at 0xFF.
4. Response backpressure: rsp_ready=0 for 10 cycles after rsp_valid → rsp_rdata/rsp_timeout stable, req_ready=0, PSEL=0; rsp_ready=1 → IDLE next cycle; a queued second command is accepted on that cycle with req_ready=1.
5. Boundary: PREADY=1 in the same cycle the wait counter reaches 15 → normal completion, rsp_timeout=0, timeout_count unchanged; PREADY=1 during SETUP only → ignored, ACCESS still entered.
6. Assert PRESETn low during ACCESS → PSEL, PENABLE, busy and rsp_valid go 0 without waiting for a clock edge; after release, first command completes normally as in scenario 1.
